// File: rtl/decode_stage.sv
// RV32I decode stage with IF/ID pipeline register, JAL redirect back to fetch,
// stall/flush handling and a one-slot wrong-path squash after each taken JAL.
module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instruction,
    input  logic        stall,
    input  logic        flush,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [4:0]  id_rd,
    output logic [31:0] id_imm,
    output logic [2:0]  id_funct3,
    output logic [3:0]  id_alu_op,
    output logic        id_alu_src_imm,
    output logic        id_alu_src_pc,
    output logic        id_reg_write,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_branch,
    output logic        id_jalr,
    output logic        id_illegal,
    output logic        jump_taken,
    output logic [31:0] jump_target
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    // Strobe vector bit positions; every bit is gated by id_valid at the output.
    localparam int NUM_STROBES = 6;
    localparam int S_RW   = 0;
    localparam int S_MR   = 1;
    localparam int S_MW   = 2;
    localparam int S_BR   = 3;
    localparam int S_JALR = 4;
    localparam int S_ILL  = 5;

    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3,
                                                   input logic       bit30,
                                                   input logic       is_reg_op);
        logic [3:0] op;
        case (f3)
            3'd0:    op = (is_reg_op && bit30) ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = bit30 ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [31:0] ins;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] dec_imm;
    logic [3:0]  dec_alu_op;
    logic        dec_src_imm, dec_src_pc, dec_is_jal;
    logic [NUM_STROBES-1:0] dec_strobe;

    assign ins   = if_instruction;
    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    always_comb begin
        dec_imm     = 32'd0;
        dec_alu_op  = ALU_ADD;
        dec_src_imm = 1'b0;
        dec_src_pc  = 1'b0;
        dec_is_jal  = 1'b0;
        dec_strobe  = '0;
        case (ins[6:0])
            OPC_LUI: begin
                dec_imm = imm_u; dec_alu_op = ALU_PASS_B; dec_src_imm = 1'b1;
                dec_strobe[S_RW] = 1'b1;
            end
            OPC_AUIPC: begin
                dec_imm = imm_u; dec_src_imm = 1'b1; dec_src_pc = 1'b1;
                dec_strobe[S_RW] = 1'b1;
            end
            OPC_JAL: begin
                dec_imm = imm_j; dec_src_pc = 1'b1; dec_is_jal = 1'b1;
                dec_strobe[S_RW] = 1'b1;
            end
            OPC_JALR: begin
                dec_imm = imm_i; dec_src_imm = 1'b1;
                dec_strobe[S_RW] = 1'b1; dec_strobe[S_JALR] = 1'b1;
            end
            OPC_BRANCH: begin
                dec_imm = imm_b; dec_alu_op = ALU_SUB;
                dec_strobe[S_BR] = 1'b1;
            end
            OPC_LOAD: begin
                dec_imm = imm_i; dec_src_imm = 1'b1;
                dec_strobe[S_RW] = 1'b1; dec_strobe[S_MR] = 1'b1;
            end
            OPC_STORE: begin
                dec_imm = imm_s; dec_src_imm = 1'b1;
                dec_strobe[S_MW] = 1'b1;
            end
            OPC_OPIMM: begin
                dec_imm = imm_i; dec_src_imm = 1'b1;
                dec_alu_op = alu_from_funct3(ins[14:12], ins[30], 1'b0);
                dec_strobe[S_RW] = 1'b1;
            end
            OPC_OP: begin
                dec_alu_op = alu_from_funct3(ins[14:12], ins[30], 1'b1);
                dec_strobe[S_RW] = 1'b1;
            end
            default: dec_strobe[S_ILL] = 1'b1;
        endcase
        // Writes to x0 are architectural no-ops, so never request them.
        if (ins[11:7] == 5'd0)
            dec_strobe[S_RW] = 1'b0;
    end

    logic        valid_reg, squash_pending_reg, jump_taken_reg;
    logic [31:0] pc_reg, imm_reg, jump_target_reg;
    logic [4:0]  rs1_reg, rs2_reg, rd_reg;
    logic [2:0]  funct3_reg;
    logic [3:0]  alu_op_reg;
    logic        src_imm_reg, src_pc_reg;
    logic [NUM_STROBES-1:0] strobe_reg;
    logic        valid_next, jal_capture;

    assign valid_next  = if_valid & ~squash_pending_reg;
    assign jal_capture = valid_next & dec_is_jal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg          <= 1'b0;
            squash_pending_reg <= 1'b0;
            jump_taken_reg     <= 1'b0;
            jump_target_reg    <= 32'd0;
            pc_reg             <= RESET_PC;
            imm_reg            <= 32'd0;
            rs1_reg            <= 5'd0;
            rs2_reg            <= 5'd0;
            rd_reg             <= 5'd0;
            funct3_reg         <= 3'd0;
            alu_op_reg         <= 4'd0;
            src_imm_reg        <= 1'b0;
            src_pc_reg         <= 1'b0;
            strobe_reg         <= '0;
        end else if (flush) begin
            valid_reg          <= 1'b0;
            jump_taken_reg     <= 1'b0;
            squash_pending_reg <= 1'b0;
        end else if (stall) begin
            // Redirect is a single-cycle pulse; fetch has already seen it.
            jump_taken_reg     <= 1'b0;
        end else begin
            valid_reg          <= valid_next;
            squash_pending_reg <= jal_capture;
            jump_taken_reg     <= jal_capture;
            jump_target_reg    <= if_pc + imm_j;
            pc_reg             <= if_pc;
            imm_reg            <= dec_imm;
            rs1_reg            <= ins[19:15];
            rs2_reg            <= ins[24:20];
            rd_reg             <= ins[11:7];
            funct3_reg         <= ins[14:12];
            alu_op_reg         <= dec_alu_op;
            src_imm_reg        <= dec_src_imm;
            src_pc_reg         <= dec_src_pc;
            strobe_reg         <= dec_strobe;
        end
    end

    logic [NUM_STROBES-1:0] strobe_out;

    generate
        for (genvar gi = 0; gi < NUM_STROBES; gi++) begin : g_strobe_gate
            assign strobe_out[gi] = strobe_reg[gi] & valid_reg;
        end
    endgenerate

    assign id_valid       = valid_reg;
    assign id_pc          = pc_reg;
    assign id_rs1         = rs1_reg;
    assign id_rs2         = rs2_reg;
    assign id_rd          = rd_reg;
    assign id_imm         = imm_reg;
    assign id_funct3      = funct3_reg;
    assign id_alu_op      = alu_op_reg;
    assign id_alu_src_imm = src_imm_reg;
    assign id_alu_src_pc  = src_pc_reg;
    assign id_reg_write   = strobe_out[S_RW];
    assign id_mem_read    = strobe_out[S_MR];
    assign id_mem_write   = strobe_out[S_MW];
    assign id_branch      = strobe_out[S_BR];
    assign id_jalr        = strobe_out[S_JALR];
    assign id_illegal     = strobe_out[S_ILL];
    assign jump_taken     = jump_taken_reg & valid_reg;
    assign jump_target    = jump_target_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases from the test plan, then
// randomized traffic checked against a cycle-level behavioural model.
module tb_decode_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = 32'd0;
    logic [31:0] if_instruction = 32'd0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_imm;
    logic [2:0]  id_funct3;
    logic [3:0]  id_alu_op;
    logic        id_alu_src_imm, id_alu_src_pc;
    logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_jalr, id_illegal;
    logic        jump_taken;
    logic [31:0] jump_target;

    int checks = 0;
    int errors = 0;

    decode_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
        .if_instruction(if_instruction), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_imm(id_imm), .id_funct3(id_funct3), .id_alu_op(id_alu_op),
        .id_alu_src_imm(id_alu_src_imm), .id_alu_src_pc(id_alu_src_pc),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_branch(id_branch), .id_jalr(id_jalr),
        .id_illegal(id_illegal), .jump_taken(jump_taken), .jump_target(jump_target)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] imm;
        logic [3:0]  op;
        logic        simm, spc, rw, mr, mw, br, jalr, ill, jal;
    } dec_t;

    // Reference model state: what the stage should present after the last edge.
    logic        m_valid, m_jt, m_sq;
    logic [31:0] m_pc, m_ins, m_tgt;
    dec_t        m_dec;

    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t d;
        logic [31:0] sgn, i_imm, s_imm, b_imm, u_imm, j_imm;
        logic [3:0]  f3_ops [8];
        f3_ops = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        sgn   = w[31] ? 32'hFFFF_FFFF : 32'd0;
        i_imm = 32'($signed(w) >>> 20);
        s_imm = (i_imm & ~32'h1F) | 32'(w[11:7]);
        b_imm = (sgn & 32'hFFFF_F000) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
        u_imm = w & 32'hFFFF_F000;
        j_imm = (sgn & 32'hFFF0_0000) | (w & 32'h000F_F000) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
        d = '0;
        case (w[6:0])
            7'b0110111: begin d.imm = u_imm; d.op = 4'd10; d.simm = 1; d.rw = 1; end
            7'b0010111: begin d.imm = u_imm; d.simm = 1; d.spc = 1; d.rw = 1; end
            7'b1101111: begin d.imm = j_imm; d.spc = 1; d.rw = 1; d.jal = 1; end
            7'b1100111: begin d.imm = i_imm; d.simm = 1; d.rw = 1; d.jalr = 1; end
            7'b1100011: begin d.imm = b_imm; d.op = 4'd1; d.br = 1; end
            7'b0000011: begin d.imm = i_imm; d.simm = 1; d.rw = 1; d.mr = 1; end
            7'b0100011: begin d.imm = s_imm; d.simm = 1; d.mw = 1; end
            7'b0010011, 7'b0110011: begin
                d.op = f3_ops[w[14:12]];
                if (w[14:12] == 3'd5 && w[30]) d.op = 4'd7;
                if (w[14:12] == 3'd0 && w[30] && w[5]) d.op = 4'd1;
                d.imm  = w[5] ? 32'd0 : i_imm;
                d.simm = !w[5];
                d.rw   = 1;
            end
            default: d.ill = 1;
        endcase
        if (w[11:7] == 5'd0) d.rw = 0;
        return d;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_jt = 0; m_sq = 0;
        m_pc = RST_PC; m_ins = 0; m_tgt = 0; m_dec = '0;
    endtask

    task automatic model_edge();
        if (flush) begin
            m_valid = 0; m_jt = 0; m_sq = 0;
        end else if (stall) begin
            m_jt = 0;
        end else begin
            m_dec   = ref_decode(if_instruction);
            m_valid = if_valid && !m_sq;
            m_pc    = if_pc;
            m_ins   = if_instruction;
            m_jt    = m_valid && m_dec.jal;
            m_sq    = m_jt;
            if (m_jt) m_tgt = if_pc + m_dec.imm;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        check("id_valid", 32'(id_valid), 32'(m_valid));
        check("jump_taken", 32'(jump_taken), 32'(m_jt));
        check("reg_write", 32'(id_reg_write), 32'(m_valid & m_dec.rw));
        check("mem_read", 32'(id_mem_read), 32'(m_valid & m_dec.mr));
        check("mem_write", 32'(id_mem_write), 32'(m_valid & m_dec.mw));
        check("branch", 32'(id_branch), 32'(m_valid & m_dec.br));
        check("jalr", 32'(id_jalr), 32'(m_valid & m_dec.jalr));
        check("illegal", 32'(id_illegal), 32'(m_valid & m_dec.ill));
        if (m_valid) begin
            check("id_pc", id_pc, m_pc);
            check("rs1", 32'(id_rs1), 32'(m_ins[19:15]));
            check("rs2", 32'(id_rs2), 32'(m_ins[24:20]));
            check("rd", 32'(id_rd), 32'(m_ins[11:7]));
            check("imm", id_imm, m_dec.imm);
            check("funct3", 32'(id_funct3), 32'(m_ins[14:12]));
            check("alu_op", 32'(id_alu_op), 32'(m_dec.op));
            check("src_imm", 32'(id_alu_src_imm), 32'(m_dec.simm));
            check("src_pc", 32'(id_alu_src_pc), 32'(m_dec.spc));
        end
        if (m_jt) check("jump_target", jump_target, m_tgt);
    endtask

    // One clock of traffic: drive, clock, advance the model, compare.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic st, input logic fl);
        if_valid = v; if_pc = pc; if_instruction = ins; stall = st; flush = fl;
        @(posedge clk);
        model_edge();
        #1;
        $display("txn v=%0d pc=%h ins=%h st=%0d fl=%0d -> id_valid=%0d jt=%0d", v, pc, ins, st, fl, id_valid, jump_taken);
        check_model();
    endtask

    task automatic check_reset_state();
        check("rst_valid", 32'(id_valid), 32'd0);
        check("rst_pc", id_pc, RST_PC);
        check("rst_imm", id_imm, 32'd0);
        check("rst_rd", 32'(id_rd), 32'd0);
        check("rst_alu_op", 32'(id_alu_op), 32'd0);
        check("rst_jt", 32'(jump_taken), 32'd0);
        check("rst_tgt", jump_target, 32'd0);
        check("rst_rw", 32'(id_reg_write), 32'd0);
    endtask

    logic [6:0] opcodes [9];

    initial begin
        logic [31:0] pc, w;
        opcodes = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                    7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
        model_reset();
        #12;
        check_reset_state();
        #1 reset = 1'b0;

        step(1, 32'h00, 32'h00500093, 0, 0);
        check("addi_imm", id_imm, 32'd5);
        check("addi_rd", 32'(id_rd), 32'd1);
        check("addi_src_imm", 32'(id_alu_src_imm), 32'd1);
        check("addi_rw", 32'(id_reg_write), 32'd1);
        step(1, 32'h04, 32'h402081B3, 0, 0);
        check("sub_op", 32'(id_alu_op), 32'd1);
        check("sub_rd", 32'(id_rd), 32'd3);
        step(1, 32'h08, 32'h0020A223, 0, 0);
        check("sw_mw", 32'(id_mem_write), 32'd1);
        check("sw_imm", id_imm, 32'd4);
        check("sw_rw", 32'(id_reg_write), 32'd0);
        step(1, 32'h10, 32'hFE208EE3, 0, 0);
        check("beq_br", 32'(id_branch), 32'd1);
        check("beq_imm", id_imm, 32'hFFFF_FFFC);
        step(1, 32'h20, 32'h008000EF, 0, 0);
        check("jal_jt", 32'(jump_taken), 32'd1);
        check("jal_tgt", jump_target, 32'h28);
        step(1, 32'h24, 32'h00000013, 0, 0);
        check("squash_valid", 32'(id_valid), 32'd0);
        check("squash_jt", 32'(jump_taken), 32'd0);
        step(1, 32'h28, 32'h00000013, 0, 0);
        check("after_squash_valid", 32'(id_valid), 32'd1);

        // Stall with changing inputs, then flush during the stall.
        step(1, 32'h2C, 32'h00100113, 0, 0);
        for (int i = 0; i < 3; i++) step(1, $urandom, $urandom, 1, 0);
        check("stall_pc", id_pc, 32'h2C);
        step(1, 32'h30, 32'h00000013, 1, 1);
        check("flush_valid", 32'(id_valid), 32'd0);

        step(1, 32'h30, 32'h0000007F, 0, 0);
        check("illegal_flag", 32'(id_illegal), 32'd1);
        check("illegal_imm", id_imm, 32'd0);

        // JAL then stall: redirect lasts one cycle; squash survives the stall.
        step(1, 32'h40, 32'h0100006F, 0, 0);
        step(1, 32'h44, 32'h00000013, 1, 0);
        check("stall_jt_drop", 32'(jump_taken), 32'd0);
        step(1, 32'h44, 32'h00000013, 0, 0);
        // Back-to-back JALs, and a flush coincident with a JAL.
        step(1, 32'h50, 32'h008000EF, 0, 0);
        step(1, 32'h54, 32'h008000EF, 0, 0);
        step(1, 32'h58, 32'h008000EF, 0, 1);
        step(1, 32'h5C, 32'h00000013, 0, 0);

        // Asynchronous reset while a squash is pending.
        step(1, 32'h60, 32'h008000EF, 0, 0);
        reset = 1'b1;
        #1;
        model_reset();
        check_reset_state();
        #1 reset = 1'b0;
        step(1, 32'h64, 32'h00000013, 0, 0);
        check("post_reset_valid", 32'(id_valid), 32'd1);

        pc = 32'h1000;
        for (int n = 0; n < 1500; n++) begin
            w = $urandom;
            if ($urandom_range(0, 9) != 0) w[6:0] = opcodes[$urandom_range(0, 8)];
            step($urandom_range(0, 9) != 0, pc, w,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5);
            pc = m_jt ? m_tgt : pc + 32'd4;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
